mult_rr_arbiter: RTL and testbench

- Shares one registered 8x8 multiplier datapath among N_REQ requesters, using round-robin arbitration.
- Each request carries operands A and B plus a per-request signed/unsigned mode bit.
- One operation is in flight at a time. The result is returned on a single valid/ready response channel, tagged with the requester ID.
- Sits between the processing lanes and the shared multiplier, so lanes never instantiate their own multiplier.

---
 rtl/mult_rr_arbiter_pkg.sv | 38 +++
 rtl/mult_rr_arbiter_core.sv | 24 ++
 rtl/mult_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_mult_rr_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_rr_arbiter_pkg.sv
// Shared constants, FSM encoding and round-robin pick helper for the
// shared-multiplier arbiter.
package mult_pkg;

   localparam int unsigned MULT_W  = 8;
   localparam int unsigned PROD_W  = 16;
   localparam int unsigned MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // First set bit of valid scanning upward from ptr, wrapping at n_req.
   // Returns 0 when nothing is valid; callers gate on any-valid separately.
   function automatic logic [2:0] rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input logic [2:0]         ptr,
      input int unsigned        n_req
   );
      logic [3:0] sum;
      logic       found;
      rr_pick = '0;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         sum = {1'b0, ptr} + 4'(k);
         if (sum >= 4'(n_req)) begin
            sum = sum - 4'(n_req);
         end
         if (!found && (k < n_req) && valid[sum[2:0]]) begin
            rr_pick = sum[2:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mult_rr_arbiter_core.sv
// Combinational W x W multiplier with selectable signed/unsigned mode.
module mult_core
   import mult_pkg::*;
#(
   parameter int unsigned W = MULT_W
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  logic           signed_i,
   output logic [2*W-1:0] prod_o
);

   logic [2*W-1:0] a_ext;
   logic [2*W-1:0] b_ext;

   // Extend both operands to the product width (sign- or zero-extension);
   // the low 2*W bits of the product are then correct for either mode.
   always_comb begin
      a_ext  = {{W{signed_i & a_i[W-1]}}, a_i};
      b_ext  = {{W{signed_i & b_i[W-1]}}, b_i};
      prod_o = a_ext * b_ext;
   end

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one registered multiplier among N_REQ lanes.
// One operation in flight: IDLE (grant) -> MUL (register product) -> OUT.
module mult_rr_arbiter
   import mult_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W     = MULT_W,
   parameter int unsigned IDW   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   input  logic [N_REQ-1:0]   req_signed,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*W-1:0]     rsp_prod,
   output logic [IDW-1:0]     rsp_id,
   output logic               busy
);

   state_t            state_q, state_d;
   logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [W-1:0]      op_a_q, op_a_d;
   logic [W-1:0]      op_b_q, op_b_d;
   logic              op_sgn_q, op_sgn_d;
   logic [IDW-1:0]    op_id_q, op_id_d;
   logic [2*W-1:0]    rsp_prod_q, rsp_prod_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;

   logic [MAX_REQ-1:0] valid_ext;
   logic [IDW-1:0]     winner;
   logic [2*W-1:0]     core_prod;

   mult_core #(
      .W (W)
   ) u_core (
      .a_i      (op_a_q),
      .b_i      (op_b_q),
      .signed_i (op_sgn_q),
      .prod_o   (core_prod)
   );

   // Round-robin winner among the currently valid requesters.
   always_comb begin
      valid_ext              = '0;
      valid_ext[N_REQ-1:0]   = req_valid;
      winner                 = IDW'(rr_pick(valid_ext, 3'(rr_ptr_q), N_REQ));
   end

   // Next-state, grant and datapath-register updates.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_sgn_d   = op_sgn_q;
      op_id_d    = op_id_q;
      rsp_prod_d = rsp_prod_q;
      rsp_id_d   = rsp_id_q;
      req_ready  = '0;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready[winner] = 1'b1;
               op_a_d            = req_a[winner*W +: W];
               op_b_d            = req_b[winner*W +: W];
               op_sgn_d          = req_signed[winner];
               op_id_d           = winner;
               state_d           = MUL;
            end
         end
         MUL: begin
            rsp_prod_d = core_prod;
            rsp_id_d   = op_id_q;
            state_d    = OUT;
         end
         OUT: begin
            if (rsp_ready) begin
               state_d  = IDLE;
               rr_ptr_d = (op_id_q == IDW'(N_REQ - 1)) ? '0 : op_id_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_sgn_q   <= 1'b0;
         op_id_q    <= '0;
         rsp_prod_q <= '0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_sgn_q   <= op_sgn_d;
         op_id_q    <= op_id_d;
         rsp_prod_q <= rsp_prod_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   // Response and status outputs decoded from registered state.
   always_comb begin
      rsp_valid = (state_q == OUT);
      busy      = (state_q != IDLE);
      rsp_prod  = rsp_prod_q;
      rsp_id    = rsp_id_q;
   end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed self-checking bench for mult_rr_arbiter.
module tb_mult_rr_arbiter;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*W-1:0]  req_a;
   logic [N*W-1:0]  req_b;
   logic [N-1:0]    req_signed;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [2*W-1:0]  rsp_prod;
   logic [1:0]      rsp_id;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   mult_rr_arbiter #(
      .N_REQ (N),
      .W     (W),
      .IDW   (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_prod   (rsp_prod),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int lane, input logic [7:0] a, input logic [7:0] b, input logic s);
      req_a[lane*W +: W] = a;
      req_b[lane*W +: W] = b;
      req_signed[lane]   = s;
      req_valid[lane]    = 1'b1;
   endtask

   // Expects an IDLE cycle granting 'lane', then a result 2 cycles later,
   // consumed with rsp_ready high. 'drop' releases the lane after grant.
   task automatic serve(input int lane, input logic [15:0] exp_prod, input bit drop, input string tag);
      #2;
      check({tag, "_grant"}, 32'(req_ready), 32'(1 << lane));
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      tick();
      if (drop) req_valid[lane] = 1'b0;
      #1;
      check({tag, "_mul_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_mul_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_mul_busy"}, 32'(busy), 32'd1);
      tick();
      check({tag, "_out_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_prod"}, 32'(rsp_prod), 32'(exp_prod));
      check({tag, "_id"}, 32'(rsp_id), 32'(lane));
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_signed = '0;
      rsp_ready  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_prod", 32'(rsp_prod), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();

      // Single unsigned op on lane 0: 51*5 = 255.
      set_lane(0, 8'd51, 8'd5, 1'b0);
      serve(0, 16'h00FF, 1'b1, "u51x5");
      check("after_idle_valid", 32'(rsp_valid), 32'd0);

      // Same bits, signed then unsigned: -51*5 = -255, 205*5 = 1025.
      set_lane(1, 8'hCD, 8'd5, 1'b1);
      serve(1, 16'hFF01, 1'b1, "sCDx5");
      set_lane(1, 8'hCD, 8'd5, 1'b0);
      serve(1, 16'h0401, 1'b1, "uCDx5");

      // Reset to bring rr_ptr to 0, then continuous requests on all lanes.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_lane(0, 8'd51, 8'd5, 1'b0);
      set_lane(1, 8'hCD, 8'd5, 1'b1);
      set_lane(2, 8'd16, 8'hF0, 1'b1);
      set_lane(3, 8'h80, 8'd127, 1'b1);
      serve(0, 16'h00FF, 1'b0, "rr0");
      serve(1, 16'hFF01, 1'b0, "rr1");
      serve(2, 16'hFF00, 1'b0, "rr2");
      serve(3, 16'hC080, 1'b0, "rr3");
      serve(0, 16'h00FF, 1'b1, "rr0b");
      req_valid = '0;
      #1;
      check("rr_all_idle_ready", 32'(req_ready), 32'd0);
      tick();

      // Extremes (rr_ptr is 1 here; lane 0 alone wraps around).
      set_lane(0, 8'h80, 8'h80, 1'b1);
      serve(0, 16'h4000, 1'b1, "s_m128sq");
      set_lane(1, 8'hFF, 8'hFF, 1'b0);
      serve(1, 16'hFE01, 1'b1, "u255sq");

      // Backpressure: lane 0 result held while lane 3 waits.
      set_lane(0, 8'd3, 8'd7, 1'b0);
      #2;
      check("bp_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      set_lane(3, 8'd2, 8'd9, 1'b0);
      rsp_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_prod", 32'(rsp_prod), 32'h0015);
         check("bp_id", 32'(rsp_id), 32'd0);
         check("bp_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      serve(3, 16'h0012, 1'b1, "bp_lane3");

      // Reset while in MUL: result must never appear.
      set_lane(2, 8'd5, 8'd5, 1'b0);
      #2;
      check("ab_grant2", 32'(req_ready), 32'h4);
      tick();
      req_valid[2] = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ab_valid", 32'(rsp_valid), 32'd0);
      check("ab_busy", 32'(busy), 32'd0);
      check("ab_prod", 32'(rsp_prod), 32'd0);
      check("ab_id", 32'(rsp_id), 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("ab_no_rsp", 32'(rsp_valid), 32'd0);
      end
      // rr_ptr back at 0: with all lanes valid, lane 0 wins.
      set_lane(0, 8'd6, 8'd7, 1'b0);
      set_lane(1, 8'd1, 8'd1, 1'b0);
      set_lane(2, 8'd1, 8'd1, 1'b0);
      set_lane(3, 8'd1, 8'd1, 1'b0);
      serve(0, 16'd42, 1'b1, "post_rst");
      req_valid = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
